i2c_slave_tx_controller: RTL and testbench
==========================================

# i2c_slave_tx_controller

Sequencing controller for the slave-transmit (master-read) phase of the I2C slave. It pulls bytes from a valid/ready transmit source and drives one `I2C_slave_write_byte` instance per byte through its enable/data/load/finish interface. It then samples the master's ACK/NACK on the 9th SCL clock and either fetches the next byte or ends the transfer. It sits between the slave's address/command decoder, which starts it, and the byte serializer.

## Interface
- `FILL_BYTE`, 8'hFF: byte transmitted on TX underrun (only with fill macro).
- `CNT_W`, 8: width of the transmitted-byte counter.
- `clock`  in  1  system clock. Single clock domain.
- `reset_n`  in  1  **synchronous, active-low** reset.
- `start`  in  1  one-cycle pulse from the address decoder. Asserted during the high phase of the address-ACK SCL clock.
- `stop_det`  in  1  one-cycle pulse on a bus STOP or repeated-START; aborts the transfer.
- `scl`  in  1  synchronized SCL.
- `sda`  in  1  synchronized SDA line value.
- `tx_valid` / `tx_data[7:0]`  in  1/8  transmit byte source.
- `tx_ready`  out  1  one-cycle pulse; the byte is consumed in that cycle.
- `wb_enable`  out  1  one-cycle start pulse to the byte serializer.
- `wb_data`  out  1  current bit to the serializer (MSB of the shift register).
- `wb_load`  in  1  serializer requests the next bit.
- `wb_finish`  in  1  serializer has completed 8 bits.
- `scl_hold`  out  1  request to stretch SCL low.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of the transfer.
- `nack`  out  1  status, valid with `done`: 1 means the master NACKed.
- `aborted`  out  1  status, valid with `done`: 1 means the transfer ended on `stop_det`.
- `byte_cnt[CNT_W-1:0]`  out  bytes completed (ACKed or NACKed) since the last `start`. Saturating.

## Operation
- The block has an internal SCL edge detector: it registers the previous SCL value, which resets to 1. `rise` = !prev & scl; `fall` = prev & !scl.
- State machine:
  - IDLE: on `start`, clear `byte_cnt`, `nack` and `aborted`, then go to FETCH.
  - FETCH:
    - If `tx_valid`: load `tx_data` into the shift register, pulse `tx_ready`, go to ARM.
    - Else: underrun (see Configuration).
  - ARM: on `fall`, pulse `wb_enable`, go to SEND.
  - SEND:
    - `wb_data` = shreg[7].
    - On `wb_load`, shreg <= {shreg[6:0],1'b0}.
    - On `wb_finish`, go to ACKW.
  - ACKW: on the next `rise`, sample `sda` and increment `byte_cnt`, saturating at all-ones.
    - `sda`=0 (ACK): go to FETCH.
    - `sda`=1 (NACK): set `nack`, pulse `done`, go to IDLE.
- `stop_det` in any non-IDLE state:
  - Go to IDLE next cycle, set `aborted`, pulse `done`.
  - A fetched-but-unsent byte is discarded and not returned to the source.
  - `scl_hold` drops.
- `stop_det` in IDLE is ignored.
- `start` while busy is ignored.
- `start` and `stop_det` in the same cycle from IDLE: `stop_det` wins and the block stays IDLE with no `done`.

## Timing
- Reset values: IDLE; every output 0; shift register 0; SCL history 1.
- `tx_ready` is asserted in the cycle after FETCH is entered with `tx_valid` high. `tx_data` is captured in that same cycle.
- The `wb_enable` pulse occurs in the cycle in which `fall` is detected, registered, i.e. one clock after SCL goes low.
- A `rise` coincident with `wb_finish` is not treated as the ACK clock. The ACK is the first `rise` strictly after the cycle in which ACKW is entered.
- FETCH→ARM completes within 2 clocks after the ACK `rise`. SCL high must therefore be ≥3 clocks.
- `done`, `nack` and `aborted` are registered. `nack` and `aborted` hold their values until the next `start`.

## Configuration
- `I2C_SLAVE_TX_UNDERRUN_FILL_EN` defined: on FETCH with `tx_valid`=0, load `FILL_BYTE`, do not pulse `tx_ready`, go to ARM. `scl_hold` is never asserted.
- Undefined: on FETCH with `tx_valid`=0, assert `scl_hold` and stay in FETCH.
  - `scl_hold` deasserts in the cycle in which `tx_valid` is accepted.
  - The byte is then sent on the next `fall`, which the master produces after the stretch is released.

## Structure
- Shared package `i2c_slave_pkg`: state encoding (IDLE, FETCH, ARM, SEND, ACKW), `I2C_ACK`=1'b0, `I2C_NACK`=1'b1.
- One sub-module, `i2c_scl_edge_detect` (clock, reset_n, scl → rise, fall), reusable by the other slave controllers.

## Test plan
- Bytes 8'h13, 8'h57, 8'h9B with master ACK after the first two and NACK after the third, SCL period 8 clocks:
  - SDA carries 13/57/9B MSB-first.
  - 3 `tx_ready` pulses.
  - `done`=1, `nack`=1, `aborted`=0, `byte_cnt`=3.
- Single byte 8'hDF, ACKed, then `stop_det` during the next FETCH/ARM → `done`, `aborted`=1, `byte_cnt`=1.
- `tx_valid` low for 20 clocks at the second byte:
  - Without the macro: `scl_hold` high until the byte is accepted, then 8'hA5 is sent intact.
  - With the macro: 8'hFF is sent and `tx_ready` is not pulsed.
- Synchronous reset asserted mid-SEND (bit 4 of 8'h3C) → next cycle IDLE with all outputs 0; a fresh `start` then transmits correctly.
- `start` and `stop_det` in the same cycle from IDLE → no `busy`, no `done`. A second `start` while busy → ignored, and `byte_cnt` is not cleared.
- `wb_finish` coincident with an SCL `rise` → that edge is not sampled as the ACK. The master drives SDA=1 on that edge and 0 on the next rise; the result must be ACK.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave controllers: transmit-sequencer state
// encoding and the ACK/NACK bit values seen on SDA during the 9th clock.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ARM,
        SEND,
        ACKW
    } tx_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_tx_controller_if.sv
// Bus bundle between the slave-transmit sequencer and its environment
// (address decoder, transmit byte source, byte serializer, SCL/SDA sync).
interface i2c_slave_tx_controller_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop_det;
    logic             scl;
    logic             sda;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             wb_enable;
    logic             wb_data;
    logic             wb_load;
    logic             wb_finish;
    logic             scl_hold;
    logic             busy;
    logic             done;
    logic             nack;
    logic             aborted;
    logic [CNT_W-1:0] byte_cnt;

    modport slave (
        input  start, stop_det, scl, sda, tx_valid, tx_data, wb_load, wb_finish,
        output tx_ready, wb_enable, wb_data, scl_hold, busy, done, nack, aborted, byte_cnt
    );

    modport master (
        output start, stop_det, scl, sda, tx_valid, tx_data, wb_load, wb_finish,
        input  tx_ready, wb_enable, wb_data, scl_hold, busy, done, nack, aborted, byte_cnt
    );

endinterface

// File: rtl/i2c_scl_edge_detect.sv
// Rising/falling edge detector on the synchronized SCL line. The history flop
// resets to 1 (idle bus level) so leaving reset with SCL high is not an edge.
module i2c_scl_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic scl,
    output logic rise,
    output logic fall
);

    logic scl_prev_q;
    logic scl_prev_d;

    assign scl_prev_d = scl;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scl_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_prev_d;
        end
    end

    assign rise = !scl_prev_q && scl;
    assign fall = scl_prev_q && !scl;

endmodule

// File: rtl/i2c_slave_tx_controller.sv
// Slave-transmit (master-read) sequencer: fetches bytes, drives the byte
// serializer and samples the master ACK. Underrun behaviour: I2C_SLAVE_TX_UNDERRUN_FILL_EN.
module i2c_slave_tx_controller
    import i2c_slave_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = 8'hFF,
    parameter int         CNT_W     = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    i2c_slave_tx_controller_if.slave    bus
);

`ifdef I2C_SLAVE_TX_UNDERRUN_FILL_EN
    localparam bit UNDERRUN_FILL = 1'b1;
`else
    localparam bit UNDERRUN_FILL = 1'b0;
`endif

    tx_state_e        state_q,     state_d;
    logic [7:0]       shreg_q,     shreg_d;
    logic [CNT_W-1:0] byte_cnt_q,  byte_cnt_d;
    logic             tx_ready_q,  tx_ready_d;
    logic             wb_enable_q, wb_enable_d;
    logic             scl_hold_q,  scl_hold_d;
    logic             done_q,      done_d;
    logic             nack_q,      nack_d;
    logic             aborted_q,   aborted_d;
    logic             scl_rise,    scl_fall;

    i2c_scl_edge_detect u_scl_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .scl     (bus.scl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        byte_cnt_d  = byte_cnt_q;
        nack_d      = nack_q;
        aborted_d   = aborted_q;
        tx_ready_d  = 1'b0;
        wb_enable_d = 1'b0;
        scl_hold_d  = 1'b0;
        done_d      = 1'b0;

        if (state_q != IDLE && bus.stop_det) begin
            // A byte already fetched but not yet sent is simply dropped.
            state_d   = IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop_det) begin
                        byte_cnt_d = '0;
                        nack_d     = 1'b0;
                        aborted_d  = 1'b0;
                        state_d    = FETCH;
                    end
                end
                FETCH: begin
                    if (bus.tx_valid) begin
                        shreg_d    = bus.tx_data;
                        tx_ready_d = 1'b1;
                        state_d    = ARM;
                    end else if (UNDERRUN_FILL) begin
                        shreg_d = FILL_BYTE;
                        state_d = ARM;
                    end else begin
                        scl_hold_d = 1'b1;
                    end
                end
                ARM: begin
                    if (scl_fall) begin
                        wb_enable_d = 1'b1;
                        state_d     = SEND;
                    end
                end
                SEND: begin
                    if (bus.wb_load) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                    // A rise in this same cycle belongs to the 8th bit, never the ACK.
                    if (bus.wb_finish) begin
                        state_d = ACKW;
                    end
                end
                ACKW: begin
                    if (scl_rise) begin
                        if (byte_cnt_q != '1) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                        if (bus.sda == I2C_NACK) begin
                            nack_d  = 1'b1;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the shift register is reset along with the control flops so wb_data
    // reads 0 straight out of reset instead of leftover data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            byte_cnt_q  <= '0;
            tx_ready_q  <= 1'b0;
            wb_enable_q <= 1'b0;
            scl_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_ready_q  <= tx_ready_d;
            wb_enable_q <= wb_enable_d;
            scl_hold_q  <= scl_hold_d;
            done_q      <= done_d;
            nack_q      <= nack_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.tx_ready  = tx_ready_q;
    assign bus.wb_enable = wb_enable_q;
    assign bus.wb_data   = shreg_q[7];
    assign bus.scl_hold  = scl_hold_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.nack      = nack_q;
    assign bus.aborted   = aborted_q;
    assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_i2c_slave_tx_controller.sv
// Directed bench for i2c_slave_tx_controller: a cycle-stepped bus model (SCL master
// honouring clock stretch, byte serializer, ACK driver, tx source) plus test sequences.
module tb_i2c_slave_tx_controller;

    logic clock;
    logic reset_n;

    i2c_slave_tx_controller_if #(.CNT_W(8)) bus ();

    i2c_slave_tx_controller #(.FILL_BYTE(8'hFF), .CNT_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- bus model state ----------------
    int         ph;
    logic [7:0] src_q[$];
    int         src_delay;
    int         gap_after;
    bit         resp[8];
    bit         coinc[8];
    logic [7:0] sent[8];
    int         sent_n;
    bit         ser_active;
    int         ser_bits;
    logic [7:0] ser_byte;
    bit         ack_pending;
    int         ack_idx;
    int         ack_count;
    int         ready_cnt;
    int         done_cnt;
    int         hold_cycles;
    bit         hold_at_ready;
    bit         done_nack;
    bit         done_abort;
    logic [7:0] done_bytes;

    task automatic clear_model();
        src_q.delete();
        src_delay     = 0;
        gap_after     = -1;
        resp          = '{default: 1'b0};
        coinc         = '{default: 1'b0};
        sent          = '{default: 8'h00};
        sent_n        = 0;
        ser_active    = 0;
        ser_bits      = 0;
        ser_byte      = 8'h00;
        ack_pending   = 0;
        ack_idx       = 0;
        ack_count     = 0;
        ready_cnt     = 0;
        done_cnt      = 0;
        hold_cycles   = 0;
        hold_at_ready = 0;
        done_nack     = 0;
        done_abort    = 0;
        done_bytes    = 8'h00;
    endtask

    task automatic finish_byte();
        bus.wb_finish = 1'b1;
        ser_active    = 0;
        if (sent_n < 8) sent[sent_n] = ser_byte;
        ack_idx       = sent_n;
        ack_pending   = 1;
        sent_n++;
    endtask

    task automatic model_step();
        logic new_scl;
        bit   fall_now;
        bit   rise_now;
        if (bus.tx_ready === 1'b1) begin
            ready_cnt++;
            if (bus.scl_hold === 1'b1) hold_at_ready = 1;
            if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (bus.scl_hold === 1'b1) hold_cycles++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_nack  = bus.nack;
            done_abort = bus.aborted;
            done_bytes = bus.byte_cnt;
        end
        // SCL master: free-running 8-clock period, frozen while the slave stretches.
        if (!(bus.scl == 1'b0 && bus.scl_hold === 1'b1)) ph = (ph + 1) % 8;
        new_scl  = (ph >= 4);
        fall_now = bus.scl && !new_scl;
        rise_now = !bus.scl && new_scl;
        bus.scl  = new_scl;
        if (src_delay > 0) src_delay--;
        bus.wb_load   = 1'b0;
        bus.wb_finish = 1'b0;
        if (fall_now) bus.sda = 1'b1;
        if (rise_now && ack_pending) begin
            bus.sda     = resp[ack_idx];
            ack_pending = 0;
            ack_count++;
            if (ack_idx == gap_after) src_delay = 20;
        end
        // Byte serializer: first bit on enable, then one bit per SCL fall.
        if (bus.wb_enable === 1'b1) begin
            ser_active  = 1;
            ser_bits    = 1;
            ser_byte    = {ser_byte[6:0], bus.wb_data};
            bus.wb_load = 1'b1;
        end else if (ser_active && fall_now) begin
            if (ser_bits < 8) begin
                ser_byte    = {ser_byte[6:0], bus.wb_data};
                ser_bits++;
                bus.wb_load = 1'b1;
            end else if (coinc[sent_n]) begin
                ser_bits = 9;
            end else begin
                finish_byte();
            end
        end else if (ser_active && rise_now && ser_bits == 9) begin
            finish_byte();
        end
        bus.tx_valid = (src_q.size() > 0) && (src_delay == 0);
        bus.tx_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    initial begin
        ph            = 4;
        bus.scl       = 1'b1;
        bus.sda       = 1'b1;
        bus.wb_load   = 1'b0;
        bus.wb_finish = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        clear_model();
        forever begin
            @(negedge clock);
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        for (int i = 0; i < 64 && !(bus.scl == 1'b1 && ph <= 5); i++) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        step();
    endtask

    task automatic wait_ack(input int n, input int budget);
        for (int i = 0; i < budget && ack_count < n; i++) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.stop_det = 1'b0;
        repeat (3) step();
        check("rst_outs", {bus.tx_ready, bus.wb_enable, bus.wb_data, bus.scl_hold,
                           bus.busy, bus.done, bus.nack, bus.aborted}, 8'h00);
        check("rst_cnt", bus.byte_cnt, 8'h00);
        reset_n = 1'b1;
        repeat (4) step();

        // 13/57/9B, ACK, ACK, NACK
        clear_model();
        src_q = '{8'h13, 8'h57, 8'h9B};
        resp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pulse_start();
        check("main_busy", bus.busy, 1'b1);
        wait_done(1500);
        check("main_done",   done_cnt, 1);
        check("main_b0",     sent[0], 8'h13);
        check("main_b1",     sent[1], 8'h57);
        check("main_b2",     sent[2], 8'h9B);
        check("main_ready",  ready_cnt, 3);
        check("main_nack",   done_nack, 1'b1);
        check("main_abort",  done_abort, 1'b0);
        check("main_cnt",    done_bytes, 8'd3);
        check("main_idle",   bus.busy, 1'b0);
        repeat (4) step();

        // DF ACKed, then STOP while the next byte sits in ARM
        clear_model();
        src_q = '{8'hDF, 8'h42};
        pulse_start();
        wait_ack(1, 1000);
        check("stop_ack_seen", ack_count, 1);
        repeat (1) step();
        bus.stop_det = 1'b1;
        step();
        bus.stop_det = 1'b0;
        wait_done(20);
        check("stop_done",  done_cnt, 1);
        check("stop_abort", done_abort, 1'b1);
        check("stop_nack",  done_nack, 1'b0);
        check("stop_cnt",   done_bytes, 8'd1);
        check("stop_sent",  sent_n, 1);
        check("stop_ready", ready_cnt, 2);
        check("stop_idle",  {bus.busy, bus.scl_hold}, 2'b00);
        repeat (4) step();

        // Source underrun at the second byte
        clear_model();
        src_q     = '{8'h11, 8'hA5};
        resp      = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        gap_after = 0;
        pulse_start();
        wait_done(1500);
        check("under_done", done_cnt, 1);
        check("under_b0",   sent[0], 8'h11);
        check("under_cnt",  done_bytes, 8'd2);
`ifdef I2C_SLAVE_TX_UNDERRUN_FILL_EN
        check("under_b1",    sent[1], 8'hFF);
        check("under_ready", ready_cnt, 1);
        check("under_hold",  hold_cycles, 0);
`else
        check("under_b1",       sent[1], 8'hA5);
        check("under_ready",    ready_cnt, 2);
        check("under_hold",     hold_cycles, 19);
        check("under_hold_rdy", hold_at_ready, 1'b0);
`endif
        repeat (4) step();

        // Reset while bit 4 of 3C is on the wire, then a clean transfer
        clear_model();
        src_q = '{8'h3C};
        pulse_start();
        for (int i = 0; i < 500 && !(ser_active && ser_bits == 4); i++) step();
        check("rst_mid_bits", ser_bits, 4);
        check("rst_mid_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        step();
        check("rst_mid_outs", {bus.tx_ready, bus.wb_enable, bus.wb_data, bus.scl_hold,
                               bus.busy, bus.done, bus.nack, bus.aborted}, 8'h00);
        check("rst_mid_cnt", bus.byte_cnt, 8'h00);
        reset_n = 1'b1;
        step();
        clear_model();
        src_q = '{8'h3C};
        resp  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pulse_start();
        wait_done(1000);
        check("rst_again_done", done_cnt, 1);
        check("rst_again_byte", sent[0], 8'h3C);
        check("rst_again_cnt",  done_bytes, 8'd1);
        repeat (4) step();

        // start and stop_det together from IDLE
        clear_model();
        begin
            int busy_seen;
            busy_seen    = 0;
            bus.start    = 1'b1;
            bus.stop_det = 1'b1;
            step();
            bus.start    = 1'b0;
            bus.stop_det = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (bus.busy === 1'b1) busy_seen++;
                step();
            end
            check("startstop_busy", busy_seen, 0);
            check("startstop_done", done_cnt, 0);
        end

        // Second start while busy is ignored
        clear_model();
        src_q = '{8'h5A, 8'hC3};
        resp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pulse_start();
        wait_ack(1, 1000);
        repeat (6) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(1000);
        check("restart_done", done_cnt, 1);
        check("restart_cnt",  done_bytes, 8'd2);
        check("restart_b1",   sent[1], 8'hC3);
        repeat (4) step();

        // wb_finish coincident with SCL rise: that rise is not the ACK
        clear_model();
        src_q = '{8'h6E, 8'h81};
        resp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        coinc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pulse_start();
        wait_done(1500);
        check("coinc_done", done_cnt, 1);
        check("coinc_b0",   sent[0], 8'h6E);
        check("coinc_b1",   sent[1], 8'h81);
        check("coinc_cnt",  done_bytes, 8'd2);
        check("coinc_nack", done_nack, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
